// File: rtl/switch_block_corner_cfg.sv
// Corner switch block: right-side and top-side tracks cross-connected through a
// serially loaded, length-checked configuration with a fixed corner pattern at reset.
module switch_block_corner_cfg #(
  parameter int CHANNEL_ONEWAY_WIDTH = 4,
  parameter int REGISTERED_OUT       = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNEL_ONEWAY_WIDTH-1:0] right_in,
  input  logic [CHANNEL_ONEWAY_WIDTH-1:0] top_in,
  output logic [CHANNEL_ONEWAY_WIDTH-1:0] right_out,
  output logic [CHANNEL_ONEWAY_WIDTH-1:0] top_out,
  input  logic                            cfg_en,
  input  logic                            cfg_in,
  output logic                            cfg_out,
  input  logic                            cfg_load,
  output logic                            cfg_done,
  output logic                            cfg_err
);

  localparam int W        = CHANNEL_ONEWAY_WIDTH;
  localparam int IDX_W    = $clog2(W);
  localparam int SEL_W    = IDX_W + 1;
  localparam int CFG_BITS = 2 * W * SEL_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);
  localparam logic [SEL_W-1:0] W_SEL    = SEL_W'(W);

  // Field k (both directions) is enabled with source index (W-2-k) mod W.
  function automatic logic [CFG_BITS-1:0] corner_pattern();
    logic [CFG_BITS-1:0] p;
    int j;
    p = '0;
    for (int k = 0; k < 2 * W; k++) begin
      j = k % W;
      p[k*SEL_W +: SEL_W] = {1'b1, IDX_W'((j <= W - 2) ? (W - 2 - j) : (W - 1))};
    end
    return p;
  endfunction

  localparam logic [CFG_BITS-1:0] ACT_RST = corner_pattern();

  function automatic logic pick(input logic [W-1:0] src, input logic [SEL_W-1:0] f);
    if (f[SEL_W-1] && ({1'b0, f[IDX_W-1:0]} < W_SEL)) return src[f[IDX_W-1:0]];
    return 1'b0;
  endfunction

  typedef enum logic {RUN, SHIFT} state_e;

  state_e              state_q, state_d;
  logic [CFG_BITS-1:0] sh_q, sh_d;
  logic [CFG_BITS-1:0] act_q, act_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic [W-1:0]        right_out_d, top_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      sh_q       <= '0;
      act_q      <= ACT_RST;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      act_q      <= act_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    act_d      = act_q;
    cnt_d      = cnt_q;
    cfg_done_d = 1'b0;
    cfg_err_d  = cfg_err_q;

    case (state_q)
      RUN:     if (cfg_en)   state_d = SHIFT;
      SHIFT:   if (cfg_load) state_d = RUN;
      default: state_d = RUN;
    endcase

    // A load wins over a simultaneous shift; sh is kept so a repeat load fails.
    if (cfg_load) begin
      cnt_d = '0;
      if (cnt_q == CNT_FULL) begin
        act_d      = sh_q;
        cfg_done_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (cfg_en) begin
      sh_d = {sh_q[CFG_BITS-2:0], cfg_in};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    right_out_d = '0;
    top_out_d   = '0;
    for (int k = 0; k < W; k++) begin
      right_out_d[k] = pick(top_in, act_q[k*SEL_W +: SEL_W]);
      top_out_d[k]   = pick(right_in, act_q[(k+W)*SEL_W +: SEL_W]);
    end
  end

  generate
    if (REGISTERED_OUT != 0) begin : g_reg
      logic [W-1:0] right_out_q, top_out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          right_out_q <= '0;
          top_out_q   <= '0;
        end else begin
          right_out_q <= right_out_d;
          top_out_q   <= top_out_d;
        end
      end
      assign right_out = right_out_q;
      assign top_out   = top_out_q;
    end else begin : g_comb
      assign right_out = right_out_d;
      assign top_out   = top_out_d;
    end
  endgenerate

  assign cfg_out  = sh_q[CFG_BITS-1];
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;

endmodule
